// File: rtl/matrix_tx_fmt.sv
// Streams a stored matrix as ASCII decimal text (space-separated, CRLF per row) into uart_tx.
// Each byte waits for tx_busy low before tx_start, then for the busy high/low cycle; a stuck tx_busy stalls indefinitely.
module matrix_tx_fmt #(
  parameter int ROWS_MAX = 5,
  parameter int COLS_MAX = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        rows,
  input  logic [2:0]        cols,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_RDW  = 3'd2;
  localparam logic [2:0] S_CONV = 3'd3;
  localparam logic [2:0] S_SEND = 3'd4;
  localparam logic [2:0] S_WHI  = 3'd5;
  localparam logic [2:0] S_WLO  = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [2:0]        rows_q, rows_d;
  logic [2:0]        cols_q, cols_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        r_q, r_d;
  logic [2:0]        c_q, c_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [4:0][7:0]   byte_q, byte_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;

  logic [2:0]        rows_clamp, cols_clamp;
  logic [ADDR_W-1:0] elem_addr;
  logic [3:0]        dig_h, dig_t, dig_o;
  logic [4:0][7:0]   fmt_b;
  logic [2:0]        fmt_n;

  assign rows_clamp = (rows > 3'(ROWS_MAX)) ? 3'(ROWS_MAX) : rows;
  assign cols_clamp = (cols > 3'(COLS_MAX)) ? 3'(COLS_MAX) : cols;
  assign elem_addr  = base_q + ADDR_W'(r_q) * ADDR_W'(COLS_MAX) + ADDR_W'(c_q);

  // Digit queue: leading zeros suppressed, then ' ' or CR LF depending on column.
  always_comb begin
    dig_h = 4'(rd_data / DATA_W'(100));
    dig_t = 4'((rd_data / DATA_W'(10)) % DATA_W'(10));
    dig_o = 4'(rd_data % DATA_W'(10));
    fmt_b = '0;
    fmt_n = 3'd0;
    if (dig_h != 4'd0) begin
      fmt_b[fmt_n] = {4'h3, dig_h};
      fmt_n        = fmt_n + 3'd1;
    end
    if (dig_h != 4'd0 || dig_t != 4'd0) begin
      fmt_b[fmt_n] = {4'h3, dig_t};
      fmt_n        = fmt_n + 3'd1;
    end
    fmt_b[fmt_n] = {4'h3, dig_o};
    fmt_n        = fmt_n + 3'd1;
    if (c_q != cols_q - 3'd1) begin
      fmt_b[fmt_n] = 8'h20;
      fmt_n        = fmt_n + 3'd1;
    end else begin
      fmt_b[fmt_n] = 8'h0D;
      fmt_n        = fmt_n + 3'd1;
      fmt_b[fmt_n] = 8'h0A;
      fmt_n        = fmt_n + 3'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    base_d     = base_q;
    r_d        = r_q;
    c_d        = c_q;
    rd_addr_d  = rd_addr_q;
    byte_d     = byte_q;
    nbytes_d   = nbytes_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_d  = rows_clamp;
          cols_d  = cols_clamp;
          base_d  = base_addr;
          r_d     = 3'd0;
          c_d     = 3'd0;
          state_d = (rows_clamp == 3'd0 || cols_clamp == 3'd0) ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        rd_addr_d = elem_addr;
        state_d   = S_RDW;
      end
      S_RDW:  state_d = S_CONV;
      S_CONV: begin
        byte_d   = fmt_b;
        nbytes_d = fmt_n;
        idx_d    = 3'd0;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_data_d  = byte_q[idx_q];
          tx_start_d = 1'b1;
          state_d    = S_WHI;
        end
      end
      // The tx_start cycle itself is skipped: uart_tx cannot have raised busy yet.
      S_WHI: begin
        if (!tx_start_q && tx_busy) begin
          state_d = S_WLO;
        end
      end
      S_WLO: begin
        if (!tx_busy) begin
          if (idx_q + 3'd1 < nbytes_q) begin
            idx_d   = idx_q + 3'd1;
            state_d = S_SEND;
          end else if (c_q != cols_q - 3'd1) begin
            c_d     = c_q + 3'd1;
            state_d = S_RD;
          end else if (r_q != rows_q - 3'd1) begin
            c_d     = 3'd0;
            r_d     = r_q + 3'd1;
            state_d = S_RD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rows_q     <= 3'd0;
      cols_q     <= 3'd0;
      base_q     <= '0;
      r_q        <= 3'd0;
      c_q        <= 3'd0;
      rd_addr_q  <= '0;
      byte_q     <= '0;
      nbytes_q   <= 3'd0;
      idx_q      <= 3'd0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      base_q     <= base_d;
      r_q        <= r_d;
      c_q        <= c_d;
      rd_addr_q  <= rd_addr_d;
      byte_q     <= byte_d;
      nbytes_q   <= nbytes_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign rd_addr  = rd_addr_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);

endmodule
